// File: rtl/tmp_pkg.sv
// Shared types and defaults for the temperature-conversion scheduler.
package tmp_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SNS_RST,
        WAIT_VALID,
        INTEGRATE,
        REPORT
    } state_e;

    localparam int RST_CYC_DEF     = 2;
    localparam int TIMEOUT_CYC_DEF = 1023;

    localparam int PER_W = 16;
    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // A zero window would never sample; treat it as a single-cycle window.
    function automatic logic [7:0] win_eff(input logic [7:0] w);
        return (w == 8'd0) ? 8'd1 : w;
    endfunction

endpackage

// File: rtl/tmp_period_tmr.sv
// Free-running period timer: counts 0..period-1 and pulses tick on wrap.
module tmp_period_tmr
    import tmp_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [PER_W-1:0] period,
    output logic             tick
);

    logic [PER_W-1:0] cnt_q, cnt_d;

    // ">=" lets the count recover at once if the period shrinks below it.
    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (period == '0) begin
            cnt_d = '0;
        end else if (cnt_q >= period - PER_W'(1)) begin
            cnt_d = '0;
            tick  = 1'b1;
        end else begin
            cnt_d = cnt_q + PER_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/tmp_conv_sched.sv
// Temperature-sensor conversion scheduler: arbitrates periodic and software
// requests, sequences the sensor and counts comparator ones over a window.
//
//   state      | meaning
//   IDLE       | no conversion; grants sw_req first, then a pending periodic request
//   SNS_RST    | sns_rst held high for RST_CYC cycles
//   WAIT_VALID | waiting for sns_valid, bounded by TIMEOUT_CYC cycles
//   INTEGRATE  | counting sns_cmp=1 over the latched window
//   REPORT     | result_vld pulse, then back to IDLE
module tmp_conv_sched
    import tmp_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int RST_CYC     = RST_CYC_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [PER_W-1:0] cfg_period,
    input  logic [7:0]       cfg_window,
    input  logic             sw_req,
    output logic             sw_ack,
    output logic             sns_rst,
    input  logic             sns_valid,
    input  logic             sns_cmp,
    output logic [7:0]       result,
    output logic             result_src,
    output logic             result_vld,
    output logic             busy,
    output logic             timeout_err,
    input  logic             err_clr
);

    localparam logic [CNT_W-1:0] RST_LOAD = CNT_W'(RST_CYC - 1);
    localparam logic [CNT_W-1:0] TMO_LOAD = CNT_W'(TIMEOUT_CYC - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       acc_q, acc_d;
    logic [7:0]       win_q, win_d;
    logic [PER_W-1:0] per_q, per_d;
    logic             src_q, src_d;
    logic             pend_q, pend_d;
    logic [7:0]       result_q, result_d;
    logic             res_src_q, res_src_d;
    logic             terr_q, terr_d;
    logic             sns_rst_q, sns_rst_d;

    logic             tick;
    logic             grant_per;
    logic             timeout_hit;
    logic [PER_W-1:0] eff_period;

    // The period in force during a conversion is the one seen at its grant.
    assign eff_period = (state_q == IDLE) ? cfg_period : per_q;
    assign grant_per  = (state_q == IDLE) && !sw_req && pend_q;

    tmp_period_tmr u_period_tmr (
        .clk    (clk),
        .reset  (reset),
        .period (eff_period),
        .tick   (tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            win_q     <= 8'd1;
            per_q     <= '0;
            src_q     <= 1'b0;
            pend_q    <= 1'b0;
            result_q  <= '0;
            res_src_q <= 1'b0;
            terr_q    <= 1'b0;
            sns_rst_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            win_q     <= win_d;
            per_q     <= per_d;
            src_q     <= src_d;
            pend_q    <= pend_d;
            result_q  <= result_d;
            res_src_q <= res_src_d;
            terr_q    <= terr_d;
            sns_rst_q <= sns_rst_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        win_d       = win_q;
        per_d       = per_q;
        src_d       = src_q;
        result_d    = result_q;
        res_src_d   = res_src_q;
        timeout_hit = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (sw_req || pend_q) begin
                    state_d = SNS_RST;
                    cnt_d   = RST_LOAD;
                    src_d   = sw_req;
                    win_d   = win_eff(cfg_window);
                    per_d   = cfg_period;
                end
            end
            SNS_RST: begin
                if (cnt_q == '0) begin
                    state_d = WAIT_VALID;
                    cnt_d   = TMO_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            WAIT_VALID: begin
                if (sns_valid) begin
                    state_d = INTEGRATE;
                    cnt_d   = CNT_W'(win_q) - CNT_ONE;
                    acc_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d     = IDLE;
                    timeout_hit = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            INTEGRATE: begin
                // The last sample is folded straight into result so it is valid in REPORT.
                acc_d = acc_q + 8'(sns_cmp);
                if (cnt_q == '0) begin
                    state_d   = REPORT;
                    result_d  = acc_d;
                    res_src_d = src_q;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            REPORT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        pend_d = pend_q;
        if (grant_per) begin
            pend_d = 1'b0;
        end else if (tick) begin
            pend_d = 1'b1;
        end

        terr_d = terr_q;
        if (timeout_hit) begin
            terr_d = 1'b1;
        end else if (err_clr) begin
            terr_d = 1'b0;
        end
    end

    always_comb begin
        sw_ack     = 1'b0;
        busy       = 1'b1;
        result_vld = 1'b0;
        sns_rst_d  = (state_d == SNS_RST);
        unique case (state_q)
            IDLE: begin
                busy   = 1'b0;
                sw_ack = sw_req && !reset;
            end
            REPORT: begin
                result_vld = !reset;
            end
            default: begin
            end
        endcase
    end

    assign sns_rst     = sns_rst_q;
    assign result      = result_q;
    assign result_src  = res_src_q;
    assign timeout_err = terr_q;

endmodule
